// File: rtl/ntt_butterfly_unit_if.sv
// ntt_butterfly_unit_if: operation request and result bundle for one butterfly lane.
// div2_in exists only when BUTTERFLY_DIV2_EN is defined.
interface ntt_butterfly_unit_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 8
);
    logic             valid_in;
    logic             mode_in;
    logic [TAG_W-1:0] tag_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] rou;
`ifdef BUTTERFLY_DIV2_EN
    logic             div2_in;
`endif
    logic             valid_out;
    logic [TAG_W-1:0] tag_out;
    logic [WIDTH-1:0] outa;
    logic [WIDTH-1:0] outb;

    modport master (
        output valid_in, mode_in, tag_in, a, b, rou,
`ifdef BUTTERFLY_DIV2_EN
        output div2_in,
`endif
        input  valid_out, tag_out, outa, outb
    );

    modport slave (
        input  valid_in, mode_in, tag_in, a, b, rou,
`ifdef BUTTERFLY_DIV2_EN
        input  div2_in,
`endif
        output valid_out, tag_out, outa, outb
    );
endinterface

// File: rtl/ntt_butterfly_unit.sv
// ntt_butterfly_unit: pipelined GS/CT radix-2 butterfly, latency MULT_LAT+2 (MULT_LAT >= 3).
// Optional GS output halving for folded iNTT scaling under BUTTERFLY_DIV2_EN.
module ntt_butterfly_unit #(
    parameter int WIDTH    = 64,
    parameter int MULT_LAT = 9,
    parameter int TAG_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    ntt_butterfly_unit_if.slave bus,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   m,
    input  logic [6:0]       k2
);
    localparam int W  = WIDTH;
    localparam int L  = MULT_LAT + 2;
    localparam int XD = MULT_LAT - 2;

    typedef struct packed {
        logic             md;
`ifdef BUTTERFLY_DIV2_EN
        logic             d2;
`endif
        logic [TAG_W-1:0] tag;
    } sb_t;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] md);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= {1'b0, md}) ? W'(s - {1'b0, md}) : W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] md);
        return (x >= y) ? x - y : x - y + md;
    endfunction

    // Barrett remainder is below 3q; two conditional subtractions finish it
    function automatic logic [W-1:0] reduce3(input logic [W+1:0] v, input logic [W-1:0] md);
        logic [W+1:0] r1;
        r1 = (v >= {2'b0, md}) ? v - {2'b0, md} : v;
        return (r1 >= {2'b0, md}) ? W'(r1 - {2'b0, md}) : W'(r1);
    endfunction

`ifdef BUTTERFLY_DIV2_EN
    function automatic logic [W-1:0] half(input logic [W-1:0] x, input logic [W-1:0] md);
        logic [W:0] s;
        s = x[0] ? {1'b0, x} + {1'b0, md} : {1'b0, x};
        return W'(s >> 1);
    endfunction
`endif

    logic [W-1:0]   op_s0;
    logic [W-1:0]   w_s0;
    logic [W-1:0]   u_pipe [MULT_LAT+1];
    logic [2*W-1:0] x_pipe [XD];
    logic [W+1:0]   x_e;
    logic [W-1:0]   qh;
    logic [W-1:0]   t;
    logic [3*W:0]   prod_m;
    logic [W+1:0]   r;
    logic [L-2:0]   vp;
    sb_t            sb [L-1];
    sb_t            f;
    logic [W-1:0]   u;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;

    // GS multiplies the difference and delays the sum; CT multiplies b and delays a
    always_ff @(posedge clk) begin
        op_s0     <= bus.mode_in ? bus.b : mod_sub(bus.a, bus.b, q);
        w_s0      <= bus.rou;
        u_pipe[0] <= bus.mode_in ? bus.a : mod_add(bus.a, bus.b, q);
        for (int i = 1; i <= MULT_LAT; i++) u_pipe[i] <= u_pipe[i-1];
    end

    always_comb begin
        prod_m = {{(W+1){1'b0}}, x_pipe[XD-1]} * {{(2*W){1'b0}}, m};
        r      = x_e - {2'b0, qh} * {2'b0, q};
    end

    always_ff @(posedge clk) begin
        x_pipe[0] <= {{W{1'b0}}, op_s0} * {{W{1'b0}}, w_s0};
        for (int i = 1; i < XD; i++) x_pipe[i] <= x_pipe[i-1];
        qh        <= W'(prod_m >> k2);
        x_e       <= x_pipe[XD-1][W+1:0];
        t         <= reduce3(r, q);
    end

    always_ff @(posedge clk) begin
        vp    <= rst ? '0 : {vp[L-3:0], bus.valid_in};
        sb[0] <= '{md: bus.mode_in,
`ifdef BUTTERFLY_DIV2_EN
                   d2: bus.div2_in,
`endif
                   tag: bus.tag_in};
        for (int i = 1; i < L-1; i++) sb[i] <= sb[i-1];
    end

    assign f = sb[L-2];
    assign u = u_pipe[MULT_LAT];

    always_comb begin
        ra = f.md ? mod_add(u, t, q) : u;
        rb = f.md ? mod_sub(u, t, q) : t;
`ifdef BUTTERFLY_DIV2_EN
        ra = (!f.md && f.d2) ? half(ra, q) : ra;
        rb = (!f.md && f.d2) ? half(rb, q) : rb;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valid_out <= 1'b0;
            bus.outa      <= '0;
            bus.outb      <= '0;
            bus.tag_out   <= '0;
        end else begin
            bus.valid_out <= vp[L-2];
            if (vp[L-2]) begin
                bus.outa    <= ra;
                bus.outb    <= rb;
                bus.tag_out <= f.tag;
            end
        end
    end
endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// tb_ntt_butterfly_unit: directed vector table plus interleave and mid-stream reset sequences.
module tb_ntt_butterfly_unit;
    localparam int W  = 64;
    localparam int TW = 8;
    localparam int ML = 9;
    localparam int L  = ML + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  q   = 64'd97;
    logic [W:0]    m   = 65'd168;
    logic [6:0]    k2  = 7'd14;

    always #5 clk = ~clk;

    ntt_butterfly_unit_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    ntt_butterfly_unit #(.WIDTH(W), .MULT_LAT(ML), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .q(q), .m(m), .k2(k2)
    );

    typedef struct {
        logic         md;
        logic         d2;
        logic [W-1:0] a, b, w, ea, eb;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic md, input logic d2, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] w, input logic [TW-1:0] tg);
        bus.valid_in = v;
        bus.mode_in  = md;
        bus.tag_in   = tg;
        bus.a        = a;
        bus.b        = b;
        bus.rou      = w;
`ifdef BUTTERFLY_DIV2_EN
        bus.div2_in  = d2;
`else
        if (d2) $display("note: div2 request ignored in this build");
`endif
    endtask

    function automatic logic [W-1:0] mulm(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x * y) % q;
    endfunction

    task automatic model(input logic md, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] w, output logic [W-1:0] ea, output logic [W-1:0] eb);
        logic [W-1:0] tt;
        tt = mulm(b, w);
        ea = md ? (a + tt) % q : (a + b) % q;
        eb = md ? (a + q - tt) % q : mulm((a + q - b) % q, w);
    endtask

    initial begin
        logic [W-1:0] ia [16];
        logic [W-1:0] ib [16];
        logic [W-1:0] iw [16];
        logic [W-1:0] ea [16];
        logic [W-1:0] eb [16];
        logic [W-1:0] ra, rb;
        int n, got, first, last, cnt, at;

        vecs.push_back('{md: 1'b0, d2: 1'b0, a: 10, b: 20, w: 5,  ea: 30, eb: 47});
        vecs.push_back('{md: 1'b1, d2: 1'b0, a: 10, b: 20, w: 5,  ea: 13, eb: 7});
        vecs.push_back('{md: 1'b0, d2: 1'b0, a: 0,  b: 1,  w: 1,  ea: 1,  eb: 96});
        vecs.push_back('{md: 1'b1, d2: 1'b0, a: 96, b: 96, w: 1,  ea: 95, eb: 0});
        vecs.push_back('{md: 1'b0, d2: 1'b0, a: 96, b: 96, w: 96, ea: 95, eb: 0});
        vecs.push_back('{md: 1'b1, d2: 1'b0, a: 0,  b: 96, w: 96, ea: 1,  eb: 96});
        vecs.push_back('{md: 1'b0, d2: 1'b0, a: 50, b: 60, w: 2,  ea: 13, eb: 77});
`ifdef BUTTERFLY_DIV2_EN
        vecs.push_back('{md: 1'b0, d2: 1'b1, a: 10, b: 20, w: 5,  ea: 15, eb: 72});
        vecs.push_back('{md: 1'b1, d2: 1'b1, a: 10, b: 20, w: 5,  ea: 13, eb: 7});
`endif

        // reset with valid_in asserted: nothing may emerge
        drive(1'b1, 1'b0, 1'b0, 64'd10, 64'd20, 64'd5, 8'hEE);
        repeat (3) tick();
        chk("rst_valid", {63'd0, bus.valid_out}, 64'd0);
        chk("rst_outa", bus.outa, 64'd0);
        chk("rst_outb", bus.outb, 64'd0);
        chk("rst_tag", {56'd0, bus.tag_out}, 64'd0);
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 8'h00);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < L + 3; c++) begin
            tick();
            if (bus.valid_out) cnt++;
        end
        chk("rst_no_ghost", cnt, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].md, vecs[i].d2, vecs[i].a, vecs[i].b, vecs[i].w, TW'(8'hA0 + i));
            tick();
            drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 8'h00);
            n = 1;
            while (!bus.valid_out && n < L + 5) begin
                tick();
                n++;
            end
            chk($sformatf("vec%0d_latency", i), n, L);
            chk($sformatf("vec%0d_outa", i), bus.outa, vecs[i].ea);
            chk($sformatf("vec%0d_outb", i), bus.outb, vecs[i].eb);
            chk($sformatf("vec%0d_tag", i), {56'd0, bus.tag_out}, 64'(8'hA0 + i));
            tick();
            chk($sformatf("vec%0d_pulse", i), {63'd0, bus.valid_out}, 64'd0);
            chk($sformatf("vec%0d_hold", i), bus.outa, vecs[i].ea);
        end

        // back-to-back alternating GS/CT
        for (int i = 0; i < 16; i++) begin
            ia[i] = 64'($urandom_range(96, 0));
            ib[i] = 64'($urandom_range(96, 0));
            iw[i] = 64'($urandom_range(96, 0));
            model(1'(i % 2), ia[i], ib[i], iw[i], ra, rb);
            ea[i] = ra;
            eb[i] = rb;
        end
        got = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 16 + L + 4; c++) begin
            if (c < 16) drive(1'b1, 1'(c % 2), 1'b0, ia[c], ib[c], iw[c], TW'(c));
            else drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 8'h00);
            tick();
            if (bus.valid_out) begin
                if (first < 0) first = c;
                last = c;
                if (got < 16) begin
                    chk($sformatf("il%0d_outa", got), bus.outa, ea[got]);
                    chk($sformatf("il%0d_outb", got), bus.outb, eb[got]);
                    chk($sformatf("il%0d_tag", got), {56'd0, bus.tag_out}, 64'(got));
                end
                got++;
            end
        end
        chk("il_count", got, 16);
        chk("il_first", first, L - 1);
        chk("il_span", last - first, 15);
        chk("il_hold_a", bus.outa, ea[15]);
        chk("il_hold_b", bus.outb, eb[15]);
        chk("il_hold_tag", {56'd0, bus.tag_out}, 64'd15);

        // reset asserted while op 3 is presented; only op 4 survives
        cnt = 0;
        at = -1;
        for (int c = 0; c < 4 + L + 4; c++) begin
            if (c < 5) drive(1'b1, 1'b0, 1'b0, 64'd10, 64'd20, 64'd5, TW'(8'h30 + c));
            else drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 8'h00);
            rst = (c == 3);
            tick();
            if (c == 3) begin
                chk("mid_rst_valid", {63'd0, bus.valid_out}, 64'd0);
                chk("mid_rst_outa", bus.outa, 64'd0);
                chk("mid_rst_outb", bus.outb, 64'd0);
                chk("mid_rst_tag", {56'd0, bus.tag_out}, 64'd0);
            end
            if (bus.valid_out) begin
                cnt++;
                at = c;
                chk("mid_rst_res_outa", bus.outa, 64'd30);
                chk("mid_rst_res_outb", bus.outb, 64'd47);
                chk("mid_rst_res_tag", {56'd0, bus.tag_out}, 64'h34);
            end
        end
        rst = 1'b0;
        chk("mid_rst_count", cnt, 1);
        chk("mid_rst_latency", at, 4 + L - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
